// File: rtl/cmd_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cmd_ctrl_pkg
// Shared definitions for the UART transmit arbiter slice:
//   - state_e               : arbiter FSM state encoding
//   - C_NUM_REQ             : default number of requesters
//   - C_STALL_TIMEOUT       : default mid-packet stall tolerance (cycles)
//   - C_STALL_CNT_W         : stall counter width (covers timeouts up to 65535)
// No ports (package).
// ---------------------------------------------------------------------------
package cmd_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_START  = 2'd2,
    S_WAIT   = 2'd3
  } state_e;

  localparam int C_NUM_REQ       = 4;
  localparam int C_STALL_TIMEOUT = 1024;
  localparam int C_STALL_CNT_W   = 16;

endpackage : cmd_ctrl_pkg

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester streams and the UART transmitter handshake.
//   i_req_valid/i_req_data/i_req_last : per-requester byte stream (byte k at [8k+7:8k])
//   o_req_ready                       : per-requester byte-accept strobe
//   o_tx_start/o_tx_data/i_tx_done    : UART transmitter handshake
//   o_grant/o_busy/o_timeout          : arbitration status
// Modports: master = requesters + UART (drives the i_* side),
//           slave  = the arbiter (drives the o_* side).
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if
  import cmd_ctrl_pkg::*;
#(
  parameter int p_num_req = C_NUM_REQ
);

  logic [p_num_req-1:0]   i_req_valid;
  logic [8*p_num_req-1:0] i_req_data;
  logic [p_num_req-1:0]   i_req_last;
  logic [p_num_req-1:0]   o_req_ready;
  logic                   o_tx_start;
  logic [7:0]             o_tx_data;
  logic                   i_tx_done;
  logic [p_num_req-1:0]   o_grant;
  logic                   o_busy;
  logic                   o_timeout;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_done,
    input  o_req_ready, o_tx_start, o_tx_data, o_grant, o_busy, o_timeout
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_done,
    output o_req_ready, o_tx_start, o_tx_data, o_grant, o_busy, o_timeout
  );

endinterface : uart_tx_arbiter_if

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin picker. Searches the request vector
// starting at (last_idx + 1) mod p_num_req and returns the first hit one-hot.
//   req      : request vector
//   last_idx : index of the previous owner (lowest priority this round)
//   grant    : one-hot winner, all-zero when no request is pending
// ---------------------------------------------------------------------------
module rr_arbiter
  import cmd_ctrl_pkg::*;
#(
  parameter int p_num_req = C_NUM_REQ
) (
  input  logic [p_num_req-1:0]         req,
  input  logic [$clog2(p_num_req)-1:0] last_idx,
  output logic [p_num_req-1:0]         grant
);

  localparam int IW = $clog2(p_num_req);

  // Rotation amount is last_idx+1, which can equal p_num_req, so one extra bit.
  logic [IW:0]          shift_s;
  logic [p_num_req-1:0] rot_s;
  logic [p_num_req-1:0] iso_s;

  // Rotate so the highest-priority requester sits at bit 0, isolate the
  // lowest set bit, then rotate the one-hot result back into place.
  always_comb begin
    shift_s = {1'b0, last_idx} + {{IW{1'b0}}, 1'b1};
    rot_s   = p_num_req'({req, req} >> shift_s);
    iso_s   = rot_s & (~rot_s + {{(p_num_req-1){1'b0}}, 1'b1});
    grant   = p_num_req'(({iso_s, iso_s} << shift_s) >> p_num_req);
  end

endmodule : rr_arbiter

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one UART transmitter between p_num_req byte-stream requesters.
// A requester owns the transmitter for a whole packet (until its last byte
// has been shifted out). An owner that stops supplying bytes mid-packet for
// p_stall_timeout cycles loses the grant and drops to lowest priority.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : uart_tx_arbiter_if.slave (requester streams, UART handshake, status)
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import cmd_ctrl_pkg::*;
#(
  parameter int p_num_req       = C_NUM_REQ,
  parameter int p_stall_timeout = C_STALL_TIMEOUT
) (
  input  logic               i_clk,
  input  logic               i_rst,
  uart_tx_arbiter_if.slave   bus
);

  localparam int IW = $clog2(p_num_req);
  localparam int CW = C_STALL_CNT_W;
  localparam logic [CW-1:0] STALL_LAST_C = CW'(p_stall_timeout - 1);
  localparam logic [IW-1:0] LAST_RST_C   = IW'(p_num_req - 1);

  state_e               state_r;
  logic [p_num_req-1:0] grant_r;
  logic [IW-1:0]        owner_idx_r;
  logic [IW-1:0]        last_owner_r;
  logic [7:0]           data_r;
  logic                 last_r;
  logic [CW-1:0]        stall_cnt_r;
  logic                 timeout_r;

  logic [p_num_req-1:0] arb_grant_s;
  logic [IW-1:0]        arb_idx_s;
  logic                 owner_valid_s;
  logic                 owner_last_s;
  logic [7:0]           owner_data_s;

  rr_arbiter #(
    .p_num_req (p_num_req)
  ) u_rr_arbiter (
    .req      (bus.i_req_valid),
    .last_idx (last_owner_r),
    .grant    (arb_grant_s)
  );

  // Encode the arbiter's one-hot winner as an index (OR works since one-hot).
  always_comb begin
    arb_idx_s = '0;
    for (int k = 0; k < p_num_req; k++) begin
      arb_idx_s = arb_idx_s | (arb_grant_s[k] ? IW'(k) : '0);
    end
  end

  // Select the current owner's valid, last flag and byte through the grant mask.
  always_comb begin
    owner_valid_s = |(bus.i_req_valid & grant_r);
    owner_last_s  = |(bus.i_req_last & grant_r);
    owner_data_s  = 8'h00;
    for (int k = 0; k < p_num_req; k++) begin
      owner_data_s = owner_data_s | (bus.i_req_data[8*k +: 8] & {8{grant_r[k]}});
    end
  end

  // Arbiter FSM with byte register, stall counter and round-robin history.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r      <= S_IDLE;
      grant_r      <= '0;
      owner_idx_r  <= '0;
      last_owner_r <= LAST_RST_C;
      data_r       <= 8'h00;
      last_r       <= 1'b0;
      stall_cnt_r  <= '0;
      timeout_r    <= 1'b0;
    end else begin
      timeout_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (|bus.i_req_valid) begin
            grant_r     <= arb_grant_s;
            owner_idx_r <= arb_idx_s;
            stall_cnt_r <= '0;
            state_r     <= S_ACCEPT;
          end else begin
            grant_r <= '0;
          end
        end
        S_ACCEPT: begin
          if (owner_valid_s) begin
            data_r      <= owner_data_s;
            last_r      <= owner_last_s;
            stall_cnt_r <= '0;
            state_r     <= S_START;
          end else if (stall_cnt_r == STALL_LAST_C) begin
            // This stalled cycle brings the count to p_stall_timeout.
            timeout_r    <= 1'b1;
            grant_r      <= '0;
            last_owner_r <= owner_idx_r;
            stall_cnt_r  <= '0;
            state_r      <= S_IDLE;
          end else begin
            stall_cnt_r <= stall_cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        S_START: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.i_tx_done) begin
            if (last_r) begin
              grant_r      <= '0;
              last_owner_r <= owner_idx_r;
              state_r      <= S_IDLE;
            end else begin
              state_r <= S_ACCEPT;
            end
          end else begin
            state_r <= S_WAIT;
          end
        end
        default: begin
          grant_r     <= '0;
          stall_cnt_r <= '0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs are direct decodes of registered state, so they carry no input paths.
  assign bus.o_req_ready = (state_r == S_ACCEPT) ? grant_r : '0;
  assign bus.o_tx_start  = (state_r == S_START);
  assign bus.o_tx_data   = data_r;
  assign bus.o_grant     = grant_r;
  assign bus.o_busy      = (state_r != S_IDLE);
  assign bus.o_timeout   = timeout_r;

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed, table-driven bench for uart_tx_arbiter (4 requesters, stall
// timeout 4). Each table row drives one cycle of inputs and lists the
// outputs expected just after the following rising edge. The stall/timeout
// scenario is a hand-written sequence.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_tx_arbiter_if #(.p_num_req(N)) bus ();

  uart_tx_arbiter #(
    .p_num_req       (N),
    .p_stall_timeout (4)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  last;
    logic        done;
    logic [3:0]  e_ready;
    logic        e_start;
    logic [7:0]  e_data;
    logic [3:0]  e_grant;
    logic        e_busy;
    logic        e_to;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

  task automatic add(input logic r, input logic [3:0] v, input logic [31:0] d,
                     input logic [3:0] l, input logic dn, input logic [3:0] er,
                     input logic es, input logic [7:0] ed, input logic [3:0] eg,
                     input logic eb, input logic et);
    vec_t x;
    x.rst = r; x.valid = v; x.data = d; x.last = l; x.done = dn;
    x.e_ready = er; x.e_start = es; x.e_data = ed; x.e_grant = eg;
    x.e_busy = eb; x.e_to = et;
    vecs.push_back(x);
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic dn);
    rst             = r;
    bus.i_req_valid = v;
    bus.i_req_data  = d;
    bus.i_req_last  = l;
    bus.i_tx_done   = dn;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] er, input logic es,
                     input logic [7:0] ed, input logic [3:0] eg, input logic eb,
                     input logic et);
    logic [18:0] act;
    logic [18:0] exp;
    act = {bus.o_req_ready, bus.o_tx_start, bus.o_tx_data, bus.o_grant, bus.o_busy, bus.o_timeout};
    exp = {er, es, ed, eg, eb, et};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ready=%b start=%b data=%h grant=%b busy=%b timeout=%b, expected ready=%b start=%b data=%h grant=%b busy=%b timeout=%b",
               nm, act[18:15], act[14], act[13:6], act[5:2], act[1], act[0],
               er, es, ed, eg, eb, et);
    end
  endtask

  initial begin
    logic [3:0] oh;
    logic [7:0] prev;
    drive(1'b1, 4'b0000, 32'h0, 4'b0000, 1'b0);

    // Reset state
    add(1, 4'b0000, 32'h0,        4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add(1, 4'b0001, 32'h0,        4'b0000, 1, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    // Single byte from req0
    add(0, 4'b0001, 32'h00000055, 4'b0001, 0, 4'b0001, 0, 8'h00, 4'b0001, 1, 0);
    add(0, 4'b0001, 32'h00000055, 4'b0001, 0, 4'b0000, 1, 8'h55, 4'b0001, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h55, 4'b0001, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h55, 4'b0000, 0, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h55, 4'b0000, 0, 0);
    // Packet hold: req1 sends A1,A2,A3 while req2 waits
    add(0, 4'b0110, 32'h0077A100, 4'b0100, 0, 4'b0010, 0, 8'h55, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A100, 4'b0100, 0, 4'b0000, 1, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A200, 4'b0100, 0, 4'b0000, 0, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A200, 4'b0100, 1, 4'b0010, 0, 8'hA1, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A200, 4'b0100, 0, 4'b0000, 1, 8'hA2, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A300, 4'b0110, 0, 4'b0000, 0, 8'hA2, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A300, 4'b0110, 1, 4'b0010, 0, 8'hA2, 4'b0010, 1, 0);
    add(0, 4'b0110, 32'h0077A300, 4'b0110, 0, 4'b0000, 1, 8'hA3, 4'b0010, 1, 0);
    add(0, 4'b0100, 32'h00770000, 4'b0100, 0, 4'b0000, 0, 8'hA3, 4'b0010, 1, 0);
    add(0, 4'b0100, 32'h00770000, 4'b0100, 1, 4'b0000, 0, 8'hA3, 4'b0000, 0, 0);
    add(0, 4'b0100, 32'h00770000, 4'b0100, 0, 4'b0100, 0, 8'hA3, 4'b0100, 1, 0);
    add(0, 4'b0100, 32'h00770000, 4'b0100, 0, 4'b0000, 1, 8'h77, 4'b0100, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h77, 4'b0100, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h77, 4'b0000, 0, 0);
    // Stray done in IDLE, then in START
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h77, 4'b0000, 0, 0);
    add(0, 4'b1000, 32'h3C000000, 4'b1000, 0, 4'b1000, 0, 8'h77, 4'b1000, 1, 0);
    add(0, 4'b1000, 32'h3C000000, 4'b1000, 0, 4'b0000, 1, 8'h3C, 4'b1000, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h3C, 4'b1000, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h3C, 4'b1000, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h3C, 4'b0000, 0, 0);
    // Fairness: all valid, single-byte packets -> owners 0,1,2,3,0
    prev = 8'h3C;
    for (int k = 0; k < 5; k++) begin
      oh = 4'b0001 << (k % 4);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0, oh,      0, prev, oh,      1, 0);
      prev = 8'hD0 + 8'(k % 4);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0, 4'b0000, 1, prev, oh,      1, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 0, 4'b0000, 0, prev, oh,      1, 0);
      add(0, 4'b1111, 32'hD3D2D1D0, 4'b1111, 1, 4'b0000, 0, prev, 4'b0000, 0, 0);
    end
    // Reset while in S_WAIT, then req0 wins over req2
    add(0, 4'b0100, 32'h00EE0000, 4'b0100, 0, 4'b0100, 0, 8'hD0, 4'b0100, 1, 0);
    add(0, 4'b0100, 32'h00EE0000, 4'b0100, 0, 4'b0000, 1, 8'hEE, 4'b0100, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'hEE, 4'b0100, 1, 0);
    add(1, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    add(0, 4'b0101, 32'h00EE0011, 4'b0101, 0, 4'b0001, 0, 8'h00, 4'b0001, 1, 0);
    add(0, 4'b0101, 32'h00EE0011, 4'b0101, 0, 4'b0000, 1, 8'h11, 4'b0001, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 0, 4'b0000, 0, 8'h11, 4'b0001, 1, 0);
    add(0, 4'b0000, 32'h00000000, 4'b0000, 1, 4'b0000, 0, 8'h11, 4'b0000, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].valid, vecs[i].data, vecs[i].last, vecs[i].done);
      step();
      chk($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_start, vecs[i].e_data,
          vecs[i].e_grant, vecs[i].e_busy, vecs[i].e_to);
    end

    // Stall timeout: req0 sends byte 1 of 2 then stalls while req3 waits
    drive(1, 4'b0000, 32'h0, 4'b0000, 0);
    step();
    chk("stall_rst", 4'b0000, 0, 8'h00, 4'b0000, 0, 0);
    drive(0, 4'b1001, 32'h330000B1, 4'b1000, 0);
    step();
    chk("stall_grant0", 4'b0001, 0, 8'h00, 4'b0001, 1, 0);
    step();
    chk("stall_start0", 4'b0000, 1, 8'hB1, 4'b0001, 1, 0);
    drive(0, 4'b1000, 32'h330000B1, 4'b1000, 0);
    step();
    chk("stall_wait0", 4'b0000, 0, 8'hB1, 4'b0001, 1, 0);
    drive(0, 4'b1000, 32'h330000B1, 4'b1000, 1);
    step();
    chk("stall_accept", 4'b0001, 0, 8'hB1, 4'b0001, 1, 0);
    drive(0, 4'b1000, 32'h330000B1, 4'b1000, 0);
    for (int c = 1; c < 4; c++) begin
      step();
      chk($sformatf("stall_cnt%0d", c), 4'b0001, 0, 8'hB1, 4'b0001, 1, 0);
    end
    step();
    chk("stall_timeout", 4'b0000, 0, 8'hB1, 4'b0000, 0, 1);
    drive(0, 4'b1001, 32'h330000B1, 4'b1000, 0);
    step();
    chk("stall_regrant3", 4'b1000, 0, 8'hB1, 4'b1000, 1, 0);
    step();
    chk("stall_start3", 4'b0000, 1, 8'h33, 4'b1000, 1, 0);
    drive(0, 4'b0000, 32'h0, 4'b0000, 0);
    step();
    chk("stall_wait3", 4'b0000, 0, 8'h33, 4'b1000, 1, 0);
    drive(0, 4'b0000, 32'h0, 4'b0000, 1);
    step();
    chk("stall_idle", 4'b0000, 0, 8'h33, 4'b0000, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: p_num_req, default 4, number of byte-stream requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter: p_stall_timeout, default 1024, idle cycles tolerated mid-packet before the grant is revoked (range 2..65535).
REQ-003 Port: i_clk, input, 1, single clock; all logic on its rising edge.
REQ-004 Port: i_rst, input, 1, reset; synchronous and active-high.
REQ-005 Port: i_req_valid, input, p_num_req, per-requester byte available.
REQ-006 Port: i_req_data, input, 8*p_num_req, per-requester byte; requester k occupies bits [8k+7:8k].
REQ-007 Port: i_req_last, input, p_num_req, per-requester flag marking the final byte of a packet.
REQ-008 Port: o_req_ready, output, p_num_req, per-requester byte-accept strobe.
REQ-009 Port: o_tx_start, output, 1, one-cycle start pulse to the UART transmitter.
REQ-010 Port: o_tx_data, output, 8, byte to transmit; stable from o_tx_start until i_tx_done.
REQ-011 Port: i_tx_done, input, 1, one-cycle pulse from the UART when the byte has been fully shifted out.
REQ-012 Port: o_grant, output, p_num_req, one-hot current owner; all-zero when idle.
REQ-013 Port: o_busy, output, 1, high whenever the FSM is not in S_IDLE.
REQ-014 Port: o_timeout, output, 1, one-cycle pulse when a grant is revoked by stall timeout.

Function
REQ-015 The FSM SHALL have the states S_IDLE, S_ACCEPT, S_START and S_WAIT, and no other states.
REQ-016 In S_IDLE with any i_req_valid high, the block SHALL grant the first valid requester searching round-robin from (last owner + 1) mod p_num_req, then enter S_ACCEPT next cycle.
REQ-017 In S_ACCEPT, o_req_ready[owner] SHALL be high combinationally; all other o_req_ready bits SHALL be low in every state.
REQ-018 In S_ACCEPT with i_req_valid[owner] high, the block SHALL register the byte and last flag, then enter S_START.
REQ-019 In S_START, o_tx_start SHALL be high for exactly one cycle, then the FSM SHALL enter S_WAIT.
REQ-020 Latency SHALL be fixed: valid seen in S_IDLE at cycle N gives ready at N+1 and o_tx_start at N+2.
REQ-021 In S_WAIT on i_tx_done, the FSM SHALL go to S_IDLE if the registered last flag is set, else to S_ACCEPT with the same owner.
REQ-022 i_tx_done SHALL be ignored in every state other than S_WAIT.
REQ-023 Grant SHALL be held for a whole packet; other requesters SHALL NOT be granted until the owner's last byte completes.
REQ-024 The last owner SHALL be updated only when a packet ends or times out.
REQ-025 A stall counter SHALL count consecutive S_ACCEPT cycles with owner valid low and clear on accept.
REQ-026 When the stall counter reaches p_stall_timeout, the block SHALL pulse o_timeout, release the grant and enter S_IDLE without issuing o_tx_start.
REQ-027 A timed-out owner SHALL take lowest round-robin priority at the next arbitration.
REQ-028 o_grant SHALL be one-hot in S_ACCEPT, S_START and S_WAIT, and zero in S_IDLE.

Reset
REQ-029 While i_rst is high, the state SHALL be S_IDLE and o_req_ready, o_tx_start, o_grant, o_busy, o_timeout, o_tx_data and the stall counter SHALL be 0.
REQ-030 At reset, the last owner SHALL be p_num_req-1 so requester 0 wins the first arbitration.
REQ-031 Reset mid-packet SHALL abandon the packet with no further o_tx_start; requesters re-present data afterwards.

Structure
REQ-032 State encodings and the default parameter values SHALL live in the shared package cmd_ctrl_pkg.
REQ-033 Round-robin selection SHALL be a sub-module rr_arbiter (request vector and last-owner index in, one-hot grant out, purely combinational).
REQ-034 The FSM, data register and stall counter SHALL remain in uart_tx_arbiter.

Verification
REQ-035 Single byte: req0 valid, data 0x55, last=1 -> ready0 at cycle 1, o_tx_start at cycle 2 with 0x55; after i_tx_done, o_busy drops next cycle.
REQ-036 Packet hold: req1 sends 3 bytes 0xA1, 0xA2, 0xA3 (last on third) while req2 is valid throughout -> three starts in order, all with o_grant=0010, before req2 is granted.
REQ-037 Fairness: all 4 requesters continuously valid with 1-byte packets -> grant order 0,1,2,3,0.
REQ-038 Stall: p_stall_timeout=4, req0 sends byte 1 of 2 then drops valid -> exactly 4 cycles later o_timeout pulses, grant clears, and a waiting req3 is granted next.
REQ-039 Stray done: i_tx_done pulsed in S_IDLE and S_START -> no state change and no extra o_tx_start.
REQ-040 Reset in S_WAIT -> next cycle all outputs 0, state S_IDLE, requester 0 wins the next arbitration.
